// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port, 1-cycle-read memory.
// Issues at most one command per cycle and steers each read response back to its requester.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_valid_out,
    input  logic                  mem_err,
    output logic                  err
);

    logic                  r_last_gnt;     // 0 = A, 1 = B
    logic                  r_mem_write;
    logic                  r_mem_read;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_issue_rd;
    logic                  r_issue_owner;
    logic                  r_resp_pending;
    logic                  r_resp_owner;
    logic                  r_err;

    logic                  w_a_gnt;
    logic                  w_b_gnt;
    logic                  w_any_gnt;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_a_rvalid;
    logic                  w_b_rvalid;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_a_gnt   = a_req & (~b_req | r_last_gnt);
        w_b_gnt   = b_req & (~a_req | ~r_last_gnt);
        w_any_gnt = w_a_gnt | w_b_gnt;
        w_wr      = w_b_gnt ? b_wr   : a_wr;
        w_addr    = w_b_gnt ? b_addr : a_addr;
        w_data    = w_b_gnt ? b_data : a_data;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_last_gnt     <= 1'b1;
            r_mem_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_address  <= '0;
            r_mem_data     <= '0;
            r_issue_rd     <= 1'b0;
            r_issue_owner  <= 1'b0;
            r_resp_pending <= 1'b0;
            r_resp_owner   <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_last_gnt    <= w_b_gnt;
                r_mem_write   <= w_wr;
                r_mem_read    <= ~w_wr;
                r_mem_address <= w_addr;
                r_mem_data    <= w_data;
            end else begin
                r_mem_write   <= 1'b0;
                r_mem_read    <= 1'b0;
                r_mem_address <= '0;
                r_mem_data    <= '0;
            end
            r_issue_rd     <= w_any_gnt & ~w_wr;
            r_issue_owner  <= w_b_gnt;
            r_resp_pending <= r_issue_rd;
            r_resp_owner   <= r_issue_owner;
            // Any response without a pending read, or a missing one, is a protocol error.
            r_err          <= r_err | mem_err | (mem_valid_out ^ r_resp_pending);
        end
    end

    always_comb begin
        w_a_rvalid = mem_valid_out & r_resp_pending & ~r_resp_owner;
        w_b_rvalid = mem_valid_out & r_resp_pending &  r_resp_owner;
    end

    assign a_gnt       = w_a_gnt;
    assign b_gnt       = w_b_gnt;
    assign a_rvalid    = w_a_rvalid;
    assign b_rvalid    = w_b_rvalid;
    assign a_rdata     = w_a_rvalid ? mem_data_out : '0;
    assign b_rdata     = w_b_rvalid ? mem_data_out : '0;
    assign mem_write   = r_mem_write;
    assign mem_read    = r_mem_read;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign err         = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural 8x6 memory, table-driven grant vectors,
// response scoreboard, plus hand sequences for error and reset-mid-read cases.
module tb_mem_port_arbiter;

    logic       clk;
    logic       RESET;
    logic       a_req, b_req, a_wr, b_wr;
    logic [2:0] a_addr, b_addr;
    logic [5:0] a_data, b_data;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [5:0] a_rdata, b_rdata;
    logic       mem_write, mem_read;
    logic [2:0] mem_address;
    logic [5:0] mem_data;
    logic [5:0] m_dout;
    logic       m_valid;
    logic       mvo;
    logic       force_valid, force_err;
    logic       err;
    logic [5:0] mm [8];

    mem_port_arbiter #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
        .clk(clk), .RESET(RESET),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_data(b_data),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_data_out(m_dout), .mem_valid_out(mvo), .mem_err(force_err),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model, reset together with the arbiter.
    always @(posedge clk) begin
        if (RESET) begin
            m_valid <= 1'b0;
            m_dout  <= '0;
            for (int i = 0; i < 8; i++) mm[i] <= '0;
        end else begin
            m_valid <= mem_read;
            m_dout  <= mem_read ? mm[mem_address] : 6'h00;
            if (mem_write) mm[mem_address] <= mem_data;
        end
    end
    assign mvo = m_valid | force_valid;

    typedef struct {
        bit       rst, ar, br, aw, bw;
        bit [2:0] aa, ba;
        bit [5:0] ad, bd;
        bit       ea, eb;
    } vec_t;

    typedef struct {
        bit       own;
        bit [5:0] data;
        int       due;
    } rsp_t;

    vec_t     tbl[$];
    rsp_t     q[$];
    int       n_cmp, n_bad, cyc;
    bit       m_last;
    bit       e_mw, e_mr, e_err;
    bit [2:0] e_addr;
    bit [5:0] e_data;
    bit [5:0] sh [8];

    function automatic vec_t mk(bit rst, bit ar, bit br, bit aw, bit bw,
                                bit [2:0] aa, bit [2:0] ba, bit [5:0] ad, bit [5:0] bd,
                                bit ea, bit eb);
        vec_t v;
        v.rst = rst; v.ar = ar; v.br = br; v.aw = aw; v.bw = bw;
        v.aa = aa; v.ba = ba; v.ad = ad; v.bd = bd; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_in(input bit rst, input bit ar, input bit br, input bit aw, input bit bw,
                          input bit [2:0] aa, input bit [2:0] ba, input bit [5:0] ad, input bit [5:0] bd);
        RESET = rst; a_req = ar; b_req = br; a_wr = aw; b_wr = bw;
        a_addr = aa; b_addr = ba; a_data = ad; b_data = bd;
    endtask

    // One cycle: check outputs at the falling edge, then advance the reference model.
    task automatic step(input bit use_exp, input bit ea_t, input bit eb_t);
        bit ga, gb, pend, own, wr;
        bit [5:0] d;
        bit [2:0] ad;
        bit [5:0] dt;
        @(negedge clk);
        ga = a_req & (~b_req | m_last);
        gb = b_req & (~a_req | ~m_last);
        if (use_exp) begin ga = ea_t; gb = eb_t; end
        chk("a_gnt", 32'(a_gnt), 32'(ga));
        chk("b_gnt", 32'(b_gnt), 32'(gb));
        chk("mem_write", 32'(mem_write), 32'(e_mw));
        chk("mem_read", 32'(mem_read), 32'(e_mr));
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_data", 32'(mem_data), 32'(e_data));
        chk("wr_rd_both", 32'(mem_write & mem_read), 32'd0);
        pend = 0; own = 0; d = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            pend = 1; own = q[0].own; d = q[0].data;
            void'(q.pop_front());
        end
        chk("a_rvalid", 32'(a_rvalid), 32'(pend & ~own));
        chk("b_rvalid", 32'(b_rvalid), 32'(pend & own));
        chk("a_rdata", 32'(a_rdata), (pend && !own) ? 32'(d) : 32'd0);
        chk("b_rdata", 32'(b_rdata), (pend && own) ? 32'(d) : 32'd0);
        chk("err", 32'(err), 32'(e_err));
        if (RESET) begin
            e_mw = 0; e_mr = 0; e_addr = '0; e_data = '0; e_err = 0; m_last = 1;
            q.delete();
            for (int i = 0; i < 8; i++) sh[i] = '0;
        end else begin
            e_err = e_err | force_err | (force_valid & ~pend);
            if (ga | gb) begin
                wr = gb ? b_wr : a_wr;
                ad = gb ? b_addr : a_addr;
                dt = gb ? b_data : a_data;
                e_mw = wr; e_mr = ~wr; e_addr = ad; e_data = dt; m_last = gb;
                if (!wr) q.push_back('{own: gb, data: sh[ad], due: cyc + 2});
                else sh[ad] = dt;
            end else begin
                e_mw = 0; e_mr = 0; e_addr = '0; e_data = '0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input bit rst);
        set_in(rst, 0, 0, 0, 0, 3'd0, 3'd0, 6'd0, 6'd0);
        step(0, 0, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        force_valid = 0; force_err = 0;
        m_last = 1; e_mw = 0; e_mr = 0; e_addr = '0; e_data = '0; e_err = 0;
        for (int i = 0; i < 8; i++) sh[i] = '0;
        set_in(1, 0, 0, 0, 0, 3'd0, 3'd0, 6'd0, 6'd0);
        @(posedge clk); #1;

        // Reset held with random requests: registered outputs stay cleared.
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            step(0, 0, 0);
        end

        // Write-then-read by A alone.
        tbl.push_back(mk(0, 1, 0, 1, 0, 3'd5, 3'd0, 6'h2A, 6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'd5, 3'd0, 6'h00, 6'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));
        // Fairness: both requesting; B reads what A wrote the cycle before.
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, 1, 1, 0, 3'(k), 3'(k - 1), 6'(16 + k), 6'h00,
                             (k % 2) == 0, (k % 2) == 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));
        // Contention on addr 7: A reads old 0, B writes 0x15, A rereads 0x15.
        tbl.push_back(mk(0, 1, 1, 0, 1, 3'd7, 3'd7, 6'h00, 6'h15, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 3'd7, 3'd7, 6'h00, 6'h15, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'd7, 3'd0, 6'h00, 6'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 3'd0, 6'h00, 6'h00, 0, 0));

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].ar, tbl[i].br, tbl[i].aw, tbl[i].bw,
                   tbl[i].aa, tbl[i].ba, tbl[i].ad, tbl[i].bd);
            step(1, tbl[i].ea, tbl[i].eb);
        end
        chk("rsp_drained", 32'(q.size()), 32'd0);

        // Spurious valid sets sticky err.
        idle(1);
        force_valid = 1; idle(0); force_valid = 0;
        for (int i = 0; i < 3; i++) idle(0);
        idle(1);
        // mem_err pulse sets sticky err.
        force_err = 1; idle(0); force_err = 0;
        for (int i = 0; i < 3; i++) idle(0);
        idle(1);

        // Reset during an in-flight read of B: no response, no error.
        set_in(0, 0, 1, 0, 0, 3'd0, 3'd2, 6'd0, 6'd0);
        step(0, 0, 0);
        idle(1);
        for (int i = 0; i < 4; i++) idle(0);
        chk("rsp_flushed", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter and sequencer for the single-port `mem` block (8 x 6-bit, 1-cycle registered read). It accepts read/write commands from requesters A and B and issues at most one command per cycle to `mem`, so write and read are never asserted together. It routes each read response back to the requester that issued it and flags protocol errors. It sits between the requesters and `mem`. At top level, `mem.RESET_L` is tied to `~RESET`.

## Interface
- DATA_WIDTH, 6, data word width
- ADDR_WIDTH, 3, address width (memory depth = 2^ADDR_WIDTH)

Ports:
- clk  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-high reset
- a_req / b_req  in  1  command request; held until granted
- a_wr / b_wr  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_WIDTH  command address
- a_data / b_data  in  DATA_WIDTH  write data
- a_gnt / b_gnt  out  1  combinational grant; command accepted at this clock edge
- a_rdata / b_rdata  out  DATA_WIDTH  read data; 0 when rvalid=0
- a_rvalid / b_rvalid  out  1  one-cycle read response strobe
- mem_write / mem_read  out  1  registered command to `mem`
- mem_address  out  ADDR_WIDTH  registered address to `mem`
- mem_data  out  DATA_WIDTH  registered write data to `mem`
- mem_data_out  in  DATA_WIDTH  from `mem.data_out`
- mem_valid_out  in  1  from `mem.valid_out`
- mem_err  in  1  from `mem.err`
- err  out  1  sticky protocol error

## Operation
**Arbitration (combinational)**
- Only A requesting: grant A. Only B requesting: grant B.
- Both requesting: grant the requester that is not `last_gnt`.
- No requests: no grant.
- At most one of a_gnt/b_gnt is high. A gnt is never high without its req.

**Accept (clock edge with gnt=1)**
- Register the winner's wr/addr/data into the command stage.
- Set `last_gnt` to the winner.
- Set `issue_owner` to the winner. Set `issue_rd` to the inverse of wr.

**Command stage (outputs for one cycle)**
- Write accepted: mem_write=1, mem_read=0.
- Read accepted: mem_read=1, mem_write=0.
- Nothing accepted: mem_write=0, mem_read=0, mem_address=0, mem_data=0.
- mem_write and mem_read are never both 1.

**Response stage**
- At each edge, shift {issue_rd, issue_owner} into {resp_pending, resp_owner}.
- rvalid for owner X = mem_valid_out & resp_pending & (resp_owner==X).
- rdata for owner X = mem_data_out when that rvalid=1, else 0.

**Error (sticky)**
- err is set on any of:
  - mem_err=1
  - mem_valid_out=1 while resp_pending=0
  - mem_valid_out=0 while resp_pending=1
- err is cleared only by RESET.

**Throughput and ordering**
- One command per cycle; back-to-back reads and writes are allowed.
- Commands execute in grant order. A read that follows a write to the same address in the next cycle returns the new data.

## Timing
- RESET=1 at an edge clears every register:
  - command stage: mem_write=0, mem_read=0, mem_address=0, mem_data=0
  - response stage: resp_pending=0, so a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0
  - err=0
  - last_gnt=B, so A wins the first tie
- gnt depends only on req and last_gnt, which is a register.
- Read latency, with grant in cycle N:
  - mem_read=1 in cycle N+1
  - mem_valid_out and the owner's rvalid high in cycle N+2
  - grant-to-rvalid = 2 cycles
- Write: grant in cycle N, mem_write=1 in cycle N+1, memory updated at the end of N+1.
- RESET while a read is in flight:
  - the command and response stages are flushed, so no rvalid is produced
  - err is not set by the flush
  - `mem` is reset in the same cycle, so its valid_out is also low

## Test plan
- **Reset:** hold RESET=1 for 2 cycles with random requests.
  - All outputs are 0.
  - First simultaneous request after release grants A.
- **Write then read, single requester:**
  - A writes addr 5, data 0x2A, then A reads addr 5.
  - mem_write=1 one cycle after the write grant.
  - a_rvalid=1 with a_rdata=0x2A exactly 2 cycles after the read grant.
  - b_rvalid stays 0 throughout.
- **Fairness:** a_req=b_req=1 for 8 cycles.
  - Grants alternate A,B,A,B,A,B,A,B.
  - mem_write and mem_read never both 1.
- **Contention and routing:** from reset, in the same cycle A reads addr 7 and B writes addr 7 with data 0x15.
  - A is granted first; a_rvalid returns 0x00.
  - A then reads addr 7 again; a_rvalid returns 0x15.
  - b_rvalid stays 0.
- **Errors:**
  - Force mem_valid_out=1 with no read pending: err=1 the next cycle and stays 1 until RESET.
  - Repeat with a forced mem_err=1 pulse: same result.
- **Reset mid-read:** grant B a read of addr 2, then assert RESET in cycle N+1.
  - b_rvalid is never asserted.
  - err=0.
  - Outputs are at reset values.
